core_wb_ctrl: RTL and testbench
===============================

Name: core_wb_ctrl

Overview:
- Writeback stage and long-latency scoreboard sitting directly upstream of the ID-stage register file.
- Arbitrates results from the single-cycle ALU path and the multi-cycle long pipe (LSU / MUL-DIV).
- Registers the winning result onto the regfile write port.
- Tracks destination registers with outstanding long-pipe writes, and forwards the just-written value to ID operand reads, since a regfile write lands only at the clock edge.

Parameters:
XLEN, 32, datapath width
RFIDX_WIDTH, 5, register index width
RF_NUM, 32, number of architectural registers (x0 hardwired zero)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous reset, active-low
alu_wb_vld  in  1  ALU result valid
alu_wb_rdy  out  1  ALU result accepted
alu_wb_wen  in  1  ALU instruction writes rd
alu_wb_idx  in  RFIDX_WIDTH  ALU rd index
alu_wb_dat  in  XLEN  ALU result
lng_wb_vld  in  1  long-pipe result valid
lng_wb_rdy  out  1  long-pipe result accepted
lng_wb_idx  in  RFIDX_WIDTH  long-pipe rd index
lng_wb_dat  in  XLEN  long-pipe result
lng_iss_vld  in  1  long-pipe instruction issuing, writes rd
lng_iss_rdy  out  1  issue permitted
lng_iss_idx  in  RFIDX_WIDTH  issuing rd index
rd_src1_idx  in  RFIDX_WIDTH  ID read index 1 (same value driven to regfile)
rd_src2_idx  in  RFIDX_WIDTH  ID read index 2
rf_src1_dat  in  XLEN  regfile read data 1
rf_src2_dat  in  XLEN  regfile read data 2
op_src1_dat  out  XLEN  forwarded operand 1
op_src2_dat  out  XLEN  forwarded operand 2
src1_busy  out  1  operand 1 awaits long-pipe write
src2_busy  out  1  operand 2 awaits long-pipe write
wb_dest_wen  out  1  regfile write enable
wb_dest_idx  out  RFIDX_WIDTH  regfile write index
wb_dest_dat  out  XLEN  regfile write data

Behaviour:
- Reset is synchronous and active-low; clk is the only clock. When rst_n=0 at a rising edge:
  - wb_dest_wen=0, wb_dest_idx=0, wb_dest_dat=0.
  - All pending bits are cleared.
  - In-flight results are dropped. Reset mid-operation discards any handshake in that cycle.
- Arbitration (combinational):
  - lng_wb_rdy=1 always; the long pipe has priority because it cannot stall.
  - alu_wb_rdy = ~lng_wb_vld.
  - Handshake = vld & rdy in the same cycle.
- Write register (1-cycle latency, registered at the edge after the handshake):
  - Long handshake: wb_dest_wen = (lng_wb_idx!=0), idx/dat from the long pipe.
  - Else ALU handshake: wb_dest_wen = alu_wb_wen & (alu_wb_idx!=0), idx/dat from the ALU.
  - Else wb_dest_wen=0; idx/dat hold their previous values.
  - Writes to x0 are accepted (rdy honoured) but never assert wen.
- Scoreboard pend[RF_NUM-1:0] (registered; pend[0] is constant 0):
  - Set: lng_iss_vld & lng_iss_rdy & lng_iss_idx!=0 sets pend[lng_iss_idx].
  - Clear: a long-pipe handshake clears pend[lng_wb_idx].
  - Set and clear on the same index in the same cycle: set wins (new issue).
  - lng_iss_rdy = ~pend[lng_iss_idx]. This is a WAW stall; at most one outstanding write per register.
  - A long result whose index is not pending is still written. Its clear is a no-op.
- Busy outputs (combinational from registered state):
  - src1_busy = pend[rd_src1_idx]; src2_busy likewise.
  - A bit clears the cycle after the long handshake. That is the same cycle wb_dest_wen is asserted for it, so forwarding covers it.
- Forwarding (combinational):
  - op_src1_dat = (wb_dest_wen & wb_dest_idx==rd_src1_idx) ? wb_dest_dat : rf_src1_dat; src2 likewise.
  - Reading index 0 always returns rf data, because wen is never set for x0.
- Every output is defined every cycle; no X propagation from idle inputs.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> wb_dest_wen=0, wb_dest_idx=0, wb_dest_dat=0, src1_busy=src2_busy=0, lng_iss_rdy=1.
- ALU writeback: alu_wb_vld=1, wen=1, idx=5, dat=0xDEADBEEF -> alu_wb_rdy=1. Next cycle wb_dest_wen=1, idx=5, dat=0xDEADBEEF. With rd_src1_idx=5, op_src1_dat=0xDEADBEEF regardless of rf_src1_dat.
- Collision: ALU (idx=3, 0x11) and long (idx=7, 0x22) valid together -> alu_wb_rdy=0, long written first (7/0x22). Next cycle the ALU is accepted and 3/0x11 is written.
- Scoreboard: issue idx=9 -> src1_busy=1 for rd_src1_idx=9, and a second issue to 9 sees lng_iss_rdy=0. Long result 9/0x55 -> next cycle src1_busy=0, wb_dest_wen=1, op_src1_dat=0x55.
- Same-cycle clear and set on idx=4 -> pend[4] remains 1.
- x0 handling: ALU or long write to idx 0 with dat=0xFFFFFFFF -> handshake completes, wb_dest_wen=0. Issue to idx 0 never sets busy.
- Mid-op reset: pend[9]=1 and a long handshake in flight, assert rst_n=0 -> next cycle pend all 0, wb_dest_wen=0.

Source files
------------

// File: rtl/core_wb_ctrl.sv
// Writeback stage: arbitrates ALU and long-pipe results onto the regfile
// write port, tracks outstanding long-pipe destinations and forwards to ID.
module core_wb_ctrl #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5,
    parameter int RF_NUM      = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_wb_vld,
    output logic                   alu_wb_rdy,
    input  logic                   alu_wb_wen,
    input  logic [RFIDX_WIDTH-1:0] alu_wb_idx,
    input  logic [XLEN-1:0]        alu_wb_dat,
    input  logic                   lng_wb_vld,
    output logic                   lng_wb_rdy,
    input  logic [RFIDX_WIDTH-1:0] lng_wb_idx,
    input  logic [XLEN-1:0]        lng_wb_dat,
    input  logic                   lng_iss_vld,
    output logic                   lng_iss_rdy,
    input  logic [RFIDX_WIDTH-1:0] lng_iss_idx,
    input  logic [RFIDX_WIDTH-1:0] rd_src1_idx,
    input  logic [RFIDX_WIDTH-1:0] rd_src2_idx,
    input  logic [XLEN-1:0]        rf_src1_dat,
    input  logic [XLEN-1:0]        rf_src2_dat,
    output logic [XLEN-1:0]        op_src1_dat,
    output logic [XLEN-1:0]        op_src2_dat,
    output logic                   src1_busy,
    output logic                   src2_busy,
    output logic                   wb_dest_wen,
    output logic [RFIDX_WIDTH-1:0] wb_dest_idx,
    output logic [XLEN-1:0]        wb_dest_dat
);

    logic [RF_NUM-1:0] pend;
    logic [RF_NUM-1:0] pend_nxt;
    logic              lng_hs;
    logic              alu_hs;
    logic              iss_hs;

    // Long pipe cannot stall, so it always wins the write port.
    assign lng_wb_rdy  = 1'b1;
    assign alu_wb_rdy  = ~lng_wb_vld;
    assign lng_hs      = lng_wb_vld & lng_wb_rdy;
    assign alu_hs      = alu_wb_vld & alu_wb_rdy;
    assign lng_iss_rdy = ~pend[lng_iss_idx];
    assign iss_hs      = lng_iss_vld & lng_iss_rdy
                         & (lng_iss_idx != '0);

    always_comb begin
        pend_nxt = pend;
        if (lng_hs) begin
            pend_nxt[lng_wb_idx] = 1'b0;
        end
        // A new issue overrides the clear of an older result.
        if (iss_hs) begin
            pend_nxt[lng_iss_idx] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_dest_wen <= 1'b0;
            wb_dest_idx <= '0;
            wb_dest_dat <= '0;
        end else if (lng_hs) begin
            wb_dest_wen <= (lng_wb_idx != '0);
            wb_dest_idx <= lng_wb_idx;
            wb_dest_dat <= lng_wb_dat;
        end else if (alu_hs) begin
            wb_dest_wen <= alu_wb_wen & (alu_wb_idx != '0);
            wb_dest_idx <= alu_wb_idx;
            wb_dest_dat <= alu_wb_dat;
        end else begin
            wb_dest_wen <= 1'b0;
        end
    end

    assign src1_busy = pend[rd_src1_idx];
    assign src2_busy = pend[rd_src2_idx];

    // The regfile only sees this write at the next edge, so bypass it now.
    assign op_src1_dat = (wb_dest_wen && wb_dest_idx == rd_src1_idx)
                         ? wb_dest_dat : rf_src1_dat;
    assign op_src2_dat = (wb_dest_wen && wb_dest_idx == rd_src2_idx)
                         ? wb_dest_dat : rf_src2_dat;

endmodule

// File: tb/tb_core_wb_ctrl.sv
// Directed table-driven bench for core_wb_ctrl: each row gives the inputs of
// one cycle and the outputs expected in that cycle before its clock edge.
module tb_core_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        alu_wb_vld;
    logic        alu_wb_rdy;
    logic        alu_wb_wen;
    logic [4:0]  alu_wb_idx;
    logic [31:0] alu_wb_dat;
    logic        lng_wb_vld;
    logic        lng_wb_rdy;
    logic [4:0]  lng_wb_idx;
    logic [31:0] lng_wb_dat;
    logic        lng_iss_vld;
    logic        lng_iss_rdy;
    logic [4:0]  lng_iss_idx;
    logic [4:0]  rd_src1_idx;
    logic [4:0]  rd_src2_idx;
    logic [31:0] rf_src1_dat;
    logic [31:0] rf_src2_dat;
    logic [31:0] op_src1_dat;
    logic [31:0] op_src2_dat;
    logic        src1_busy;
    logic        src2_busy;
    logic        wb_dest_wen;
    logic [4:0]  wb_dest_idx;
    logic [31:0] wb_dest_dat;

    int checks = 0;
    int errors = 0;

    core_wb_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_wb_vld  (alu_wb_vld),
        .alu_wb_rdy  (alu_wb_rdy),
        .alu_wb_wen  (alu_wb_wen),
        .alu_wb_idx  (alu_wb_idx),
        .alu_wb_dat  (alu_wb_dat),
        .lng_wb_vld  (lng_wb_vld),
        .lng_wb_rdy  (lng_wb_rdy),
        .lng_wb_idx  (lng_wb_idx),
        .lng_wb_dat  (lng_wb_dat),
        .lng_iss_vld (lng_iss_vld),
        .lng_iss_rdy (lng_iss_rdy),
        .lng_iss_idx (lng_iss_idx),
        .rd_src1_idx (rd_src1_idx),
        .rd_src2_idx (rd_src2_idx),
        .rf_src1_dat (rf_src1_dat),
        .rf_src2_dat (rf_src2_dat),
        .op_src1_dat (op_src1_dat),
        .op_src2_dat (op_src2_dat),
        .src1_busy   (src1_busy),
        .src2_busy   (src2_busy),
        .wb_dest_wen (wb_dest_wen),
        .wb_dest_idx (wb_dest_idx),
        .wb_dest_dat (wb_dest_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        av;
        logic        aw;
        logic [4:0]  ai;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  li;
        logic [31:0] ld;
        logic        iv;
        logic [4:0]  ii;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        e_ardy;
        logic        e_irdy;
        logic        e_b1;
        logic        e_b2;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic        e_wen;
        logic [4:0]  e_widx;
        logic [31:0] e_wdat;
    } vec_t;

    localparam int NV = 22;
    vec_t vt [NV];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n       = v.rst;
        alu_wb_vld  = v.av;
        alu_wb_wen  = v.aw;
        alu_wb_idx  = v.ai;
        alu_wb_dat  = v.ad;
        lng_wb_vld  = v.lv;
        lng_wb_idx  = v.li;
        lng_wb_dat  = v.ld;
        lng_iss_vld = v.iv;
        lng_iss_idx = v.ii;
        rd_src1_idx = v.s1;
        rd_src2_idx = v.s2;
        rf_src1_dat = v.r1;
        rf_src2_dat = v.r2;
    endtask

    initial begin
        // rst av aw ai ad | lv li ld | iv ii | s1 s2 r1 r2 |
        // ardy irdy b1 b2 op1 op2 wen widx wdat
        vt[0]  = '{1,0,0,0,0, 0,0,0, 0,0, 0,0,'hA1,'hA2,
                   1,1,0,0,'hA1,'hA2, 0,0,0};
        vt[1]  = '{1,1,1,5,'hDEADBEEF, 0,0,0, 0,0, 5,0,'h12345678,'hA2,
                   1,1,0,0,'h12345678,'hA2, 0,0,0};
        vt[2]  = '{1,0,0,0,0, 0,0,0, 0,0, 5,0,'h12345678,'hA2,
                   1,1,0,0,'hDEADBEEF,'hA2, 1,5,'hDEADBEEF};
        vt[3]  = '{1,1,1,3,'h11, 1,7,'h22, 0,0, 0,0,'hA1,'hA2,
                   0,1,0,0,'hA1,'hA2, 0,5,'hDEADBEEF};
        vt[4]  = '{1,1,1,3,'h11, 0,0,0, 0,0, 0,7,'hA1,'hA2,
                   1,1,0,0,'hA1,'h22, 1,7,'h22};
        vt[5]  = '{1,0,0,0,0, 0,0,0, 0,0, 3,0,'hA1,'hA2,
                   1,1,0,0,'h11,'hA2, 1,3,'h11};
        vt[6]  = '{1,0,0,0,0, 0,0,0, 1,9, 9,0,'hA1,'hA2,
                   1,1,0,0,'hA1,'hA2, 0,3,'h11};
        vt[7]  = '{1,0,0,0,0, 0,0,0, 1,9, 9,0,'hA1,'hA2,
                   1,0,1,0,'hA1,'hA2, 0,3,'h11};
        vt[8]  = '{1,0,0,0,0, 1,9,'h55, 0,0, 9,0,'hA1,'hA2,
                   0,1,1,0,'hA1,'hA2, 0,3,'h11};
        vt[9]  = '{1,0,0,0,0, 0,0,0, 0,0, 9,0,'hA1,'hA2,
                   1,1,0,0,'h55,'hA2, 1,9,'h55};
        vt[10] = '{1,0,0,0,0, 1,4,'h44, 1,4, 0,4,'hA1,'hA2,
                   0,1,0,0,'hA1,'hA2, 0,9,'h55};
        vt[11] = '{1,0,0,0,0, 0,0,0, 0,4, 0,4,'hA1,'hA2,
                   1,0,0,1,'hA1,'h44, 1,4,'h44};
        vt[12] = '{1,0,0,0,0, 1,4,'h66, 0,0, 0,4,'hA1,'hA2,
                   0,1,0,1,'hA1,'hA2, 0,4,'h44};
        vt[13] = '{1,0,0,0,0, 0,0,0, 0,0, 0,4,'hA1,'hA2,
                   1,1,0,0,'hA1,'h66, 1,4,'h66};
        vt[14] = '{1,1,1,0,'hFFFFFFFF, 0,0,0, 1,0, 0,0,'hA1,'hA2,
                   1,1,0,0,'hA1,'hA2, 0,4,'h66};
        vt[15] = '{1,0,0,0,0, 1,0,'hFFFFFFFF, 0,0, 0,0,'hA1,'hA2,
                   0,1,0,0,'hA1,'hA2, 0,0,'hFFFFFFFF};
        vt[16] = '{1,0,0,0,0, 0,0,0, 0,0, 0,0,'hA1,'hA2,
                   1,1,0,0,'hA1,'hA2, 0,0,'hFFFFFFFF};
        vt[17] = '{1,0,0,0,0, 0,0,0, 1,9, 0,0,'hA1,'hA2,
                   1,1,0,0,'hA1,'hA2, 0,0,'hFFFFFFFF};
        vt[18] = '{0,0,0,0,0, 1,5,'h77, 0,9, 9,0,'hA1,'hA2,
                   0,0,1,0,'hA1,'hA2, 0,0,'hFFFFFFFF};
        vt[19] = '{1,0,0,0,0, 0,0,0, 0,9, 9,0,'hA1,'hA2,
                   1,1,0,0,'hA1,'hA2, 0,0,0};
        vt[20] = '{1,1,0,6,'h99, 0,0,0, 0,0, 0,0,'hA1,'hA2,
                   1,1,0,0,'hA1,'hA2, 0,0,0};
        vt[21] = '{1,0,0,0,0, 0,0,0, 0,0, 6,0,'hA1,'hA2,
                   1,1,0,0,'hA1,'hA2, 0,6,'h99};

        // Reset held for two edges with random inputs.
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            alu_wb_vld  = 1'($urandom);
            alu_wb_wen  = 1'($urandom);
            alu_wb_idx  = 5'($urandom);
            alu_wb_dat  = $urandom;
            lng_wb_vld  = 1'($urandom);
            lng_wb_idx  = 5'($urandom);
            lng_wb_dat  = $urandom;
            lng_iss_vld = 1'($urandom);
            lng_iss_idx = 5'($urandom);
            rd_src1_idx = 5'($urandom);
            rd_src2_idx = 5'($urandom);
            rf_src1_dat = $urandom;
            rf_src2_dat = $urandom;
            @(posedge clk);
            #1;
        end
        chk("rst.wen", 32'(wb_dest_wen), 32'd0);
        chk("rst.idx", 32'(wb_dest_idx), 32'd0);
        chk("rst.dat", wb_dest_dat, 32'd0);
        chk("rst.b1", 32'(src1_busy), 32'd0);
        chk("rst.b2", 32'(src2_busy), 32'd0);
        chk("rst.irdy", 32'(lng_iss_rdy), 32'd1);
        chk("rst.lrdy", 32'(lng_wb_rdy), 32'd1);

        for (int i = 0; i < NV; i++) begin
            drive(vt[i]);
            #2;
            chk($sformatf("v%0d.ardy", i), 32'(alu_wb_rdy),
                32'(vt[i].e_ardy));
            chk($sformatf("v%0d.lrdy", i), 32'(lng_wb_rdy), 32'd1);
            chk($sformatf("v%0d.irdy", i), 32'(lng_iss_rdy),
                32'(vt[i].e_irdy));
            chk($sformatf("v%0d.b1", i), 32'(src1_busy),
                32'(vt[i].e_b1));
            chk($sformatf("v%0d.b2", i), 32'(src2_busy),
                32'(vt[i].e_b2));
            chk($sformatf("v%0d.op1", i), op_src1_dat, vt[i].e_op1);
            chk($sformatf("v%0d.op2", i), op_src2_dat, vt[i].e_op2);
            chk($sformatf("v%0d.wen", i), 32'(wb_dest_wen),
                32'(vt[i].e_wen));
            chk($sformatf("v%0d.widx", i), 32'(wb_dest_idx),
                32'(vt[i].e_widx));
            chk($sformatf("v%0d.wdat", i), wb_dest_dat, vt[i].e_wdat);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
